dma_pack_fifo: RTL and testbench
================================

// Module: dma_pack_fifo
// PURPOSE
//  Parametrised byte-packing FIFO between the DMA read engine (fill side) and the write engine (drain side).
//  Accepts 1/2/4/8-byte beats at any naturally aligned lane of a DATA_BYTES-wide bus and repacks them.
//  Adds features the 32-bit DMA FIFO lacks: a generic bus width, programmable watermarks, level and
//  high-water reporting, sticky protocol-error flags, and a synchronous flush.
// PARAMETERS
//  DATA_BYTES  4   bus width in bytes; legal values are 4 and 8.
//  FIFO_BYTES  16  storage depth in bytes; a power of 2 and >= 2*DATA_BYTES.
//  PW          $clog2(FIFO_BYTES)+1   pointer/level width (derived; do not override).
// PORTS
//  clk_i       in   1            clock
//  rstn_i      in   1            asynchronous active-low reset
//  clr_i       in   1            synchronous flush (active high)
//  rvalid_i    in   1            fill beat valid
//  rready_o    out  1            fill beat accepted
//  rdata_i     in   8*DATA_BYTES fill data (lane-positioned)
//  rsize_i     in   3            fill size; bytes = 1<<rsize_i
//  rladdr_i    in   $clog2(DATA_BYTES)  fill lane offset
//  wvalid_i    in   1            drain request valid
//  wready_o    out  1            drain request accepted
//  wsize_i     in   3            drain size; bytes = 1<<wsize_i
//  wladdr_i    in   $clog2(DATA_BYTES)  drain lane offset
//  wdata_o     out  8*DATA_BYTES drain data (lane-positioned)
//  wstrb_o     out  DATA_BYTES   drain byte strobes
//  afull_th_i  in   PW           almost-full threshold (bytes)
//  aempty_th_i in   PW           almost-empty threshold (bytes)
//  level_o     out  PW           bytes held
//  hwm_o       out  PW           maximum level since the last reset or clr_i
//  afull_o     out  1            level_o >= afull_th_i
//  aempty_o    out  1            level_o <= aempty_th_i
//  err_o       out  2            sticky errors: [0] illegal fill, [1] illegal drain
// BEHAVIOUR
//  - Async reset and clr_i both clear hptr, tptr, hwm_o and err_o. The storage array is not reset.
//    After reset: level_o=0, rready_o=1, wready_o=0, wstrb_o=0, wdata_o=0, aempty_o=1, afull_o=(afull_th_i==0).
//  - Pointers are PW bits wide; the MSB is the wrap bit. level = hptr - tptr (mod 2^PW); space = FIFO_BYTES - level.
//  - A beat is legal when (1<<size) <= DATA_BYTES and ladr % (1<<size) == 0. Otherwise it is illegal.
//  - rready_o = ~clr_i & (illegal fill | space >= fill bytes).
//  - wready_o = ~clr_i & (illegal drain | level >= drain bytes); for a legal drain this requires level > 0.
//  - Ready signals are computed from the registered level only. There is no same-cycle fill-to-drain bypass.
//    Simultaneous legal fill and drain both commit; level changes by +fill bytes - drain bytes.
//  - Legal fill handshake:
//    lane bytes rdata_i[8*(ladr+k)+:8] -> fifo[(hptr+k) mod FIFO_BYTES] for k < bytes; hptr += bytes.
//  - Legal drain output (combinational from the storage array):
//    wdata_o byte lane ladr+k = fifo[(tptr+k) mod FIFO_BYTES]; wstrb_o bits ladr..ladr+bytes-1 set, others 0.
//    Unstrobed lanes drive 0. On handshake: tptr += bytes.
//  - While wvalid_i=0 or the request is illegal: wdata_o=0, wstrb_o=0.
//  - An illegal beat still handshakes, so the bus never hangs. Its data is dropped, no pointer moves,
//    and err_o[0] (fill) or err_o[1] (drain) is set. Errors stay set until reset or clr_i.
//  - hwm_o is registered: it loads next_level when next_level > hwm_o.
//  - afull_o and aempty_o are combinational from level_o and the thresholds.
//  - clr_i takes priority over any handshake in the same cycle. Both readies are 0 during clr_i,
//    so no data is lost silently.
//  - Wrap-around: multi-byte fills and drains may straddle the end of storage; indexing is modulo FIFO_BYTES.
//  - Full: level == FIFO_BYTES (wrap bits differ, low bits equal). Empty: pointers identical.
// TESTING  (DATA_BYTES=4, FIFO_BYTES=16)
//  1. Reset release -> level_o=0, rready_o=1, wready_o=0, wstrb_o=0, err_o=0, aempty_o=1.
//  2. Four size-0 fills on lanes 0..3 of 0x44332211, then a size-2 drain at lane 0
//     -> wdata_o=0x44332211, wstrb_o=0xF, level_o 4->0.
//  3. Four word fills (level 16) -> rready_o=0. Then fill and drain (size 2) together in one cycle
//     -> drain accepted, fill stalled; next cycle level 12, rready_o=1, hwm_o=16.
//  4. Fill and drain 14 bytes, then word fill 0xDDCCBBAA (straddles wrap).
//     Drain size 1 at lane 2 -> wdata_o=0xBBAA0000, wstrb_o=0xC. Drain size 1 at lane 0 -> 0x0000DDCC, 0x3.
//  5. Fill rsize=1, rladdr=1 -> handshake completes, level unchanged, err_o=2'b01.
//     Drain wsize=3 -> err_o=2'b11. Pulse clr_i -> err_o=0, level_o=0, hwm_o=0.
//  6. afull_th_i=12, aempty_th_i=2; fill bytes one at a time
//     -> aempty_o falls at level 3, afull_o rises at level 12.

Source files
------------

// File: rtl/dma_pack_fifo.sv
// Byte-packing FIFO between the DMA read (fill) and write (drain) engines.
// Lane-positioned beats of 1..DATA_BYTES bytes are repacked through a circular byte store.
module dma_pack_fifo #(
    parameter int DATA_BYTES = 4,
    parameter int FIFO_BYTES = 16,
    parameter int PW         = $clog2(FIFO_BYTES) + 1
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          clr_i,
    input  logic                          rvalid_i,
    output logic                          rready_o,
    input  logic [8*DATA_BYTES-1:0]       rdata_i,
    input  logic [2:0]                    rsize_i,
    input  logic [$clog2(DATA_BYTES)-1:0] rladdr_i,
    input  logic                          wvalid_i,
    output logic                          wready_o,
    input  logic [2:0]                    wsize_i,
    input  logic [$clog2(DATA_BYTES)-1:0] wladdr_i,
    output logic [8*DATA_BYTES-1:0]       wdata_o,
    output logic [DATA_BYTES-1:0]         wstrb_o,
    input  logic [PW-1:0]                 afull_th_i,
    input  logic [PW-1:0]                 aempty_th_i,
    output logic [PW-1:0]                 level_o,
    output logic [PW-1:0]                 hwm_o,
    output logic                          afull_o,
    output logic                          aempty_o,
    output logic [1:0]                    err_o
);
    localparam int LW = $clog2(DATA_BYTES);
    localparam int AW = $clog2(FIFO_BYTES);
    localparam int DW = 8 * DATA_BYTES;

    logic [7:0]            mem_q [FIFO_BYTES];
    logic [PW-1:0]         hptr_q, hptr_d, tptr_q, tptr_d, hwm_q, hwm_d;
    logic [1:0]            err_q, err_d;
    logic [PW-1:0]         level, space, next_level, fbytes, dbytes, fadd, dsub;
    logic [LW-1:0]         fmask, dmask;
    logic                  fill_legal, drain_legal, fill_hs, drain_hs, fill_fire, drain_fire;
    logic                  drain_show;
    logic [DW-1:0]         fill_aligned, drain_raw;
    logic [DATA_BYTES-1:0] strb_lo;

    // Pointers carry one extra wrap bit, so level distinguishes full from empty.
    assign level = hptr_q - tptr_q;
    assign space = PW'(FIFO_BYTES) - level;

    // Byte counts are only meaningful for legal sizes, which always fit in PW bits.
    assign fbytes = PW'(1) << rsize_i;
    assign dbytes = PW'(1) << wsize_i;
    assign fmask  = LW'(fbytes - PW'(1));
    assign dmask  = LW'(dbytes - PW'(1));

    assign fill_legal  = (rsize_i <= 3'(LW)) && ((rladdr_i & fmask) == '0);
    assign drain_legal = (wsize_i <= 3'(LW)) && ((wladdr_i & dmask) == '0);

    // Illegal beats always handshake so a bad request can never hang the bus.
    assign rready_o = ~clr_i & (~fill_legal | (space >= fbytes));
    assign wready_o = ~clr_i & (~drain_legal | (level >= dbytes));

    assign fill_hs    = rvalid_i & rready_o;
    assign drain_hs   = wvalid_i & wready_o;
    assign fill_fire  = fill_hs & fill_legal;
    assign drain_fire = drain_hs & drain_legal;

    assign fadd       = fill_fire ? fbytes : '0;
    assign dsub       = drain_fire ? dbytes : '0;
    assign next_level = level + fadd - dsub;

    always_comb begin
        hptr_d = hptr_q + fadd;
        tptr_d = tptr_q + dsub;
        hwm_d  = (next_level > hwm_q) ? next_level : hwm_q;
        err_d  = err_q | {drain_hs & ~drain_legal, fill_hs & ~fill_legal};
        if (clr_i) begin
            hptr_d = '0;
            tptr_d = '0;
            hwm_d  = '0;
            err_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hptr_q <= '0;
            tptr_q <= '0;
            hwm_q  <= '0;
            err_q  <= '0;
        end else begin
            hptr_q <= hptr_d;
            tptr_q <= tptr_d;
            hwm_q  <= hwm_d;
            err_q  <= err_d;
        end
    end

    // Shift the fill beat down so its first valid byte sits in lane 0.
    assign fill_aligned = rdata_i >> {rladdr_i, 3'b000};

    always_ff @(posedge clk_i) begin
        if (fill_fire) begin
            for (int k = 0; k < DATA_BYTES; k++) begin
                if (PW'(k) < fbytes) begin
                    mem_q[AW'(hptr_q) + AW'(k)] <= fill_aligned[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        strb_lo   = '0;
        drain_raw = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (PW'(k) < dbytes) begin
                strb_lo[k]         = 1'b1;
                drain_raw[8*k +: 8] = mem_q[AW'(tptr_q) + AW'(k)];
            end
        end
    end

    assign drain_show = wvalid_i & drain_legal;
    assign wdata_o    = drain_show ? (drain_raw << {wladdr_i, 3'b000}) : '0;
    assign wstrb_o    = drain_show ? (strb_lo << wladdr_i) : '0;

    assign level_o  = level;
    assign hwm_o    = hwm_q;
    assign afull_o  = (level >= afull_th_i);
    assign aempty_o = (level <= aempty_th_i);
    assign err_o    = err_q;

endmodule

// File: tb/tb_dma_pack_fifo.sv
// Bench for dma_pack_fifo: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a byte-queue model of the FIFO.
module tb_dma_pack_fifo;
  localparam int DB = 4;
  localparam int FB = 16;
  localparam int PW = 5;

  // Clock / reset and DUT stimulus signals.
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          clr = 1'b0;
  logic          rvalid = 1'b0;
  logic          wvalid = 1'b0;
  logic          rready, wready;
  logic [31:0]   rdata = '0;
  logic [31:0]   wdata;
  logic [2:0]    rsize = '0;
  logic [2:0]    wsize = '0;
  logic [1:0]    rladdr = '0;
  logic [1:0]    wladdr = '0;
  logic [3:0]    wstrb;
  logic [PW-1:0] afull_th = 5'd16;
  logic [PW-1:0] aempty_th = 5'd0;
  logic [PW-1:0] level, hwm;
  logic          afull, aempty;
  logic [1:0]    err;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  // Model state: the bytes held, in FIFO order, plus high-water mark and sticky errors.
  logic [7:0] exp_q[$];
  int         m_hwm = 0;
  logic [1:0] m_err = '0;

  dma_pack_fifo #(.DATA_BYTES(DB), .FIFO_BYTES(FB)) dut (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr),
    .rvalid_i(rvalid), .rready_o(rready), .rdata_i(rdata), .rsize_i(rsize), .rladdr_i(rladdr),
    .wvalid_i(wvalid), .wready_o(wready), .wsize_i(wsize), .wladdr_i(wladdr),
    .wdata_o(wdata), .wstrb_o(wstrb),
    .afull_th_i(afull_th), .aempty_th_i(aempty_th),
    .level_o(level), .hwm_o(hwm), .afull_o(afull), .aempty_o(aempty), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    int lvl, fb, db;
    bit fl, dl, erdy, ewrdy;
    logic [31:0] ed;
    logic [3:0] es;
    if (chk_on && rstn) begin
      lvl = exp_q.size();
      fb = 1 << rsize;
      db = 1 << wsize;
      fl = (rsize <= 3'd2) && ((int'(rladdr) % fb) == 0);
      dl = (wsize <= 3'd2) && ((int'(wladdr) % db) == 0);
      erdy = !clr && (!fl || (FB - lvl) >= fb);
      ewrdy = !clr && (!dl || lvl >= db);
      ed = '0;
      es = '0;
      if (wvalid && dl) begin
        for (int k = 0; k < db; k++) begin
          es[int'(wladdr) + k] = 1'b1;
          if (lvl >= db) ed[8*(int'(wladdr) + k) +: 8] = exp_q[k];
        end
      end
      chk("rready", 64'(rready), 64'(erdy));
      chk("wready", 64'(wready), 64'(ewrdy));
      chk("wstrb", 64'(wstrb), 64'(es));
      if (!(wvalid && dl) || lvl >= db) chk("wdata", 64'(wdata), 64'(ed));
      chk("level", 64'(level), 64'(lvl));
      chk("hwm", 64'(hwm), 64'(m_hwm));
      chk("err", 64'(err), 64'(m_err));
      chk("afull", 64'(afull), 64'(lvl >= int'(afull_th)));
      chk("aempty", 64'(aempty), 64'(lvl <= int'(aempty_th)));

      if (clr) begin
        exp_q.delete();
        m_hwm = 0;
        m_err = '0;
      end else begin
        if (wvalid && ewrdy) begin
          if (dl) repeat (db) void'(exp_q.pop_front());
          else m_err[1] = 1'b1;
        end
        if (rvalid && erdy) begin
          if (fl) for (int k = 0; k < fb; k++) exp_q.push_back(rdata[8*(int'(rladdr) + k) +: 8]);
          else m_err[0] = 1'b1;
        end
        if (exp_q.size() > m_hwm) m_hwm = exp_q.size();
      end
    end
  end

  // Driver tasks: entered and left one time unit after a rising edge.
  task automatic do_fill(input logic [2:0] sz, input logic [1:0] la, input logic [31:0] d);
    bit done;
    done = 1'b0;
    rvalid = 1'b1; rsize = sz; rladdr = la; rdata = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk); done = rready;
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    chk("fill_handshake", 64'(done), 64'd1);
  endtask

  task automatic do_drain(input logic [2:0] sz, input logic [1:0] la);
    bit done;
    done = 1'b0;
    wvalid = 1'b1; wsize = sz; wladdr = la;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk); done = wready;
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    chk("drain_handshake", 64'(done), 64'd1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    logic [2:0] sz;
    // Reset release
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    chk("t1_level", 64'(level), 64'd0);
    chk("t1_rready", 64'(rready), 64'd1);
    chk("t1_wready", 64'(wready), 64'd0);
    chk("t1_wstrb", 64'(wstrb), 64'd0);
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_aempty", 64'(aempty), 64'd1);
    @(posedge clk); #1;

    // Byte fills on each lane, repacked into one word drain
    for (int i = 0; i < 4; i++) do_fill(3'd0, 2'(i), 32'h44332211);
    wvalid = 1'b1; wsize = 3'd2; wladdr = 2'd0;
    @(negedge clk);
    chk("t2_wdata", 64'(wdata), 64'h44332211);
    chk("t2_wstrb", 64'(wstrb), 64'hF);
    chk("t2_level4", 64'(level), 64'd4);
    chk("t2_wready", 64'(wready), 64'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    chk("t2_level0", 64'(level), 64'd0);
    @(posedge clk); #1;

    // Full FIFO: simultaneous fill and drain, only the drain commits
    for (int i = 0; i < 4; i++) do_fill(3'd2, 2'd0, $urandom);
    @(negedge clk);
    chk("t3_level16", 64'(level), 64'd16);
    chk("t3_rready_full", 64'(rready), 64'd0);
    @(posedge clk); #1;
    rvalid = 1'b1; rsize = 3'd2; rladdr = 2'd0; rdata = $urandom;
    wvalid = 1'b1; wsize = 3'd2; wladdr = 2'd0;
    @(negedge clk);
    chk("t3_both_wready", 64'(wready), 64'd1);
    chk("t3_both_rready", 64'(rready), 64'd0);
    @(posedge clk); #1;
    rvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("t3_level12", 64'(level), 64'd12);
    chk("t3_rready", 64'(rready), 64'd1);
    chk("t3_hwm", 64'(hwm), 64'd16);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) do_drain(3'd2, 2'd0);

    // Wrap-around: park both pointers at 14, then straddle the end of storage
    pulse_clr();
    @(negedge clk);
    chk("t4_clr_hwm", 64'(hwm), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) do_fill(3'd1, 2'((i % 2) * 2), $urandom);
    for (int i = 0; i < 7; i++) do_drain(3'd1, 2'(((i + 1) % 2) * 2));
    do_fill(3'd2, 2'd0, 32'hDDCCBBAA);
    wvalid = 1'b1; wsize = 3'd1; wladdr = 2'd2;
    @(negedge clk);
    chk("t4_wdata_hi", 64'(wdata), 64'hBBAA0000);
    chk("t4_wstrb_hi", 64'(wstrb), 64'hC);
    @(posedge clk); #1;
    wladdr = 2'd0;
    @(negedge clk);
    chk("t4_wdata_lo", 64'(wdata), 64'h0000DDCC);
    chk("t4_wstrb_lo", 64'(wstrb), 64'h3);
    @(posedge clk); #1;
    wvalid = 1'b0;

    // Illegal beats: handshake, drop data, set sticky errors; flush clears them
    do_fill(3'd1, 2'd1, $urandom);
    @(negedge clk);
    chk("t5_level", 64'(level), 64'd0);
    chk("t5_err_fill", 64'(err), 64'b01);
    @(posedge clk); #1;
    do_drain(3'd3, 2'd0);
    @(negedge clk);
    chk("t5_err_both", 64'(err), 64'b11);
    @(posedge clk); #1;
    pulse_clr();
    @(negedge clk);
    chk("t5_clr_err", 64'(err), 64'd0);
    chk("t5_clr_level", 64'(level), 64'd0);
    chk("t5_clr_hwm", 64'(hwm), 64'd0);
    @(posedge clk); #1;

    // Watermarks, one byte at a time
    afull_th = 5'd12; aempty_th = 5'd2;
    wsize = 3'd0; wladdr = 2'd0;
    for (int i = 1; i <= 12; i++) begin
      do_fill(3'd0, 2'(i % 4), $urandom);
      @(negedge clk);
      if (i == 2) chk("t6_aempty_at2", 64'(aempty), 64'd1);
      if (i == 3) chk("t6_aempty_at3", 64'(aempty), 64'd0);
      if (i == 11) chk("t6_afull_at11", 64'(afull), 64'd0);
      if (i == 12) chk("t6_afull_at12", 64'(afull), 64'd1);
      @(posedge clk); #1;
    end
    pulse_clr();

    // Random traffic: mostly aligned beats, some illegal, occasional flush and threshold change
    for (int c = 0; c < 3000; c++) begin
      rvalid = ($urandom_range(0, 99) < 60);
      sz = 3'($urandom_range(0, 2));
      rsize = sz;
      rladdr = 2'($urandom_range(0, 3)) & ~2'((1 << sz) - 1);
      if ($urandom_range(0, 19) == 0) begin
        rsize = 3'($urandom_range(0, 7));
        rladdr = 2'($urandom_range(0, 3));
      end
      rdata = $urandom;
      wvalid = ($urandom_range(0, 99) < 55);
      sz = 3'($urandom_range(0, 2));
      wsize = sz;
      wladdr = 2'($urandom_range(0, 3)) & ~2'((1 << sz) - 1);
      if ($urandom_range(0, 19) == 0) begin
        wsize = 3'($urandom_range(0, 7));
        wladdr = 2'($urandom_range(0, 3));
      end
      clr = ($urandom_range(0, 149) == 0);
      if (c % 250 == 0) begin
        afull_th = 5'($urandom_range(0, 16));
        aempty_th = 5'($urandom_range(0, 16));
      end
      @(posedge clk); #1;
    end
    rvalid = 1'b0; wvalid = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
